// File: rtl/cpu_bus_frontend.sv
// cpu_bus_frontend: CPU-side front end of the cache.
// Generates phi2, demultiplexes the 65816 bank byte, and issues 24-bit requests
// over a valid/ready handshake. phi2 is stretched high while a request is outstanding.
// Optional macro STRETCH_TIMEOUT_EN bounds the stretch to MAX_STRETCH cycles
// and adds the o_timeout pulse output.
module cpu_bus_frontend #(
  parameter int PHI2_HALF   = 8,
  parameter int MAX_STRETCH = 64
) (
  input  logic        i_fpga,
  input  logic        i_reset,
  input  logic [15:0] i_a,
  input  logic [7:0]  i_d,
  input  logic        i_rwb,
  input  logic        i_vda,
  input  logic        i_vpa,
  output logic        o_phi2,
  output logic [7:0]  o_d_out,
  output logic        o_d_oe,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic [23:0] o_req_addr,
  output logic        o_req_we,
  output logic [7:0]  o_req_wdata,
  input  logic        i_rsp_valid,
  input  logic [7:0]  i_rsp_data
`ifdef STRETCH_TIMEOUT_EN
  ,
  output logic        o_timeout
`endif
);

  typedef enum logic [1:0] {LOW, HIGH, STRETCH, HOLD} state_t;

  localparam int CW = (PHI2_HALF > 2) ? $clog2(PHI2_HALF) : 2;
  localparam logic [CW-1:0] LAST_CNT  = CW'(PHI2_HALF - 1);
  localparam logic [CW-1:0] WDATA_CNT = CW'(PHI2_HALF - 2);

  // Reject parameter values the phase sequencing cannot honour.
  if (PHI2_HALF < 3) begin : g_badHalf
    $error("PHI2_HALF must be at least 3");
  end
  if (MAX_STRETCH < 2) begin : g_badStretch
    $error("MAX_STRETCH must be at least 2");
  end

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_reqValid;
  logic [23:0]     r_reqAddr;
  logic            r_reqWe;
  logic [7:0]      r_reqWdata;
  logic            r_act;
  logic            r_pendRd;
  logic [7:0]      r_dOut;
  logic            r_dataLatched;

  state_t          w_nextState;
  logic [CW-1:0]   w_nextCnt;
  logic            w_lastCnt;
  logic            w_accept;
  logic            w_rdOpen;
  logic            w_rspHit;
  logic            w_pendNext;
  logic            w_busy;
  logic            w_enterLow;
  logic            w_timeoutHit;

  // A read is open once accepted (or in the accepting cycle) until its response.
  assign w_lastCnt  = (r_cnt == LAST_CNT);
  assign w_accept   = r_reqValid & i_req_ready;
  assign w_rdOpen   = r_pendRd | (w_accept & ~r_reqWe);
  assign w_rspHit   = i_rsp_valid & w_rdOpen;
  assign w_pendNext = w_rdOpen & ~i_rsp_valid;
  assign w_busy     = (r_reqValid & ~i_req_ready) | w_pendNext;
  assign w_enterLow = (w_nextState == LOW) && (r_state != LOW);

`ifdef STRETCH_TIMEOUT_EN
  localparam int SW = (MAX_STRETCH > 2) ? $clog2(MAX_STRETCH) : 1;
  localparam logic [SW-1:0] STRETCH_LAST = SW'(MAX_STRETCH - 1);

  logic [SW-1:0] r_stretchCnt;
  logic          r_timeout;

  assign w_timeoutHit = (r_state == STRETCH) && w_busy && (r_stretchCnt == STRETCH_LAST);
  assign o_timeout    = r_timeout;

  // Count stretch cycles from STRETCH entry and flag the cycle the limit is reached.
  always_ff @(posedge i_fpga) begin
    if (i_reset || (r_state != STRETCH)) begin
      r_stretchCnt <= '0;
    end else begin
      r_stretchCnt <= r_stretchCnt + SW'(1);
    end
    r_timeout <= i_reset ? 1'b0 : w_timeoutHit;
  end
`else
  assign w_timeoutHit = 1'b0;
`endif

  // Phase state and phase counter register.
  always_ff @(posedge i_fpga) begin
    if (i_reset) begin
      r_state <= LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Phase sequencing: fixed LOW/HIGH halves, stretched while the cache is still busy.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    unique case (r_state)
      LOW: begin
        if (w_lastCnt) begin
          w_nextState = HIGH;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CW'(1);
        end
      end
      HIGH: begin
        if (w_lastCnt) begin
          w_nextCnt = '0;
          // Data arriving in the last HIGH cycle still gets a HOLD cycle of setup.
          if (w_busy) begin
            w_nextState = STRETCH;
          end else if (w_rspHit) begin
            w_nextState = HOLD;
          end else begin
            w_nextState = LOW;
          end
        end else begin
          w_nextCnt = r_cnt + CW'(1);
        end
      end
      STRETCH: begin
        if (!w_busy || w_timeoutHit) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        w_nextState = LOW;
        w_nextCnt   = '0;
      end
      default: begin
        w_nextState = LOW;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Request, handshake and read-data registers.
  always_ff @(posedge i_fpga) begin
    if (i_reset) begin
      r_reqValid    <= 1'b0;
      r_reqAddr     <= '0;
      r_reqWe       <= 1'b0;
      r_reqWdata    <= '0;
      r_act         <= 1'b0;
      r_pendRd      <= 1'b0;
      r_dOut        <= '0;
      r_dataLatched <= 1'b0;
    end else begin
      if ((r_state == LOW) && w_lastCnt) begin
        r_reqAddr  <= {i_d, i_a};
        r_reqWe    <= ~i_rwb;
        r_act      <= i_vda | i_vpa;
        r_reqValid <= (i_vda | i_vpa) & i_rwb;
      end
      if ((r_state == HIGH) && (r_cnt == WDATA_CNT) && r_act && r_reqWe && !r_reqValid) begin
        r_reqWdata <= i_d;
        r_reqValid <= 1'b1;
      end
      if (w_accept) begin
        r_reqValid <= 1'b0;
      end
      r_pendRd <= w_pendNext;
      if (w_rspHit) begin
        r_dOut        <= i_rsp_data;
        r_dataLatched <= 1'b1;
      end
      if (w_enterLow) begin
        r_dataLatched <= 1'b0;
      end
      if (w_timeoutHit) begin
        r_reqValid <= 1'b0;
        r_pendRd   <= 1'b0;
        if (!r_reqWe) begin
          r_dOut        <= 8'hFF;
          r_dataLatched <= 1'b1;
        end
      end
    end
  end

  assign o_phi2      = (r_state != LOW);
  assign o_d_out     = r_dOut;
  assign o_d_oe      = o_phi2 & r_act & ~r_reqWe & r_dataLatched;
  assign o_req_valid = r_reqValid;
  assign o_req_addr  = r_reqAddr;
  assign o_req_we    = r_reqWe;
  assign o_req_wdata = r_reqWdata;

endmodule

// File: tb/tb_cpu_bus_frontend.sv
// Testbench for cpu_bus_frontend with PHI2_HALF=4, MAX_STRETCH=8.
// Define STRETCH_TIMEOUT_EN to also exercise the stretch timeout.
module tb_cpu_bus_frontend;

  localparam int PHI2_HALF   = 4;
  localparam int MAX_STRETCH = 8;

  logic        clk;
  logic        i_reset;
  logic [15:0] i_a;
  logic [7:0]  i_d;
  logic        i_rwb, i_vda, i_vpa;
  logic        o_phi2;
  logic [7:0]  o_d_out;
  logic        o_d_oe;
  logic        o_req_valid;
  logic        i_req_ready;
  logic [23:0] o_req_addr;
  logic        o_req_we;
  logic [7:0]  o_req_wdata;
  logic        i_rsp_valid;
  logic [7:0]  i_rsp_data;
`ifdef STRETCH_TIMEOUT_EN
  logic        o_timeout;
`endif

  cpu_bus_frontend #(.PHI2_HALF(PHI2_HALF), .MAX_STRETCH(MAX_STRETCH)) dut (
    .i_fpga(clk), .i_reset(i_reset), .i_a(i_a), .i_d(i_d), .i_rwb(i_rwb),
    .i_vda(i_vda), .i_vpa(i_vpa), .o_phi2(o_phi2), .o_d_out(o_d_out), .o_d_oe(o_d_oe),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
    .o_req_we(o_req_we), .o_req_wdata(o_req_wdata), .i_rsp_valid(i_rsp_valid),
    .i_rsp_data(i_rsp_data)
`ifdef STRETCH_TIMEOUT_EN
    , .o_timeout(o_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } req_t;

  typedef struct {
    logic [7:0]  bank;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rwb;
    logic        vda;
    logic        vpa;
    int          rspIdx;
    logic [7:0]  rspData;
    int          readyFrom;
    int          expHigh;
    logic [7:0]  expDout;
    logic        expDoe;
  } vec_t;

  req_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   acceptCount = 0;

  logic        prevValid = 1'b0;
  logic        prevAcc = 1'b0;
  logic [23:0] prevAddr = '0;
  logic        prevWe = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic reportExpired(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=bound-expired expected=event", name);
  endtask

  // Scoreboard: every accepted request is compared with the oldest expected one.
  always @(negedge clk) begin
    if (i_reset) begin
      prevValid = 1'b0;
      prevAcc   = 1'b0;
    end else begin
      if (o_req_valid && prevValid && !prevAcc) begin
        checkOutput("heldAddr", 32'(o_req_addr), 32'(prevAddr));
        checkOutput("heldWe", 32'(o_req_we), 32'(prevWe));
      end
      if (o_req_valid && i_req_ready) begin
        acceptCount++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedReq actual=%0h expected=none", o_req_addr);
        end else begin
          req_t e;
          e = expQ.pop_front();
          checkOutput("reqAddr", 32'(o_req_addr), 32'(e.addr));
          checkOutput("reqWe", 32'(o_req_we), 32'(e.we));
          if (e.we) checkOutput("reqWdata", 32'(o_req_wdata), 32'(e.wdata));
        end
      end
      prevValid = o_req_valid;
      prevAcc   = o_req_valid & i_req_ready;
      prevAddr  = o_req_addr;
      prevWe    = o_req_we;
    end
  end

  task automatic applyReset(input string name);
    i_reset     = 1'b1;
    i_rsp_valid = 1'b0;
    i_req_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({name, "_phi2"}, 32'(o_phi2), 0);
    checkOutput({name, "_reqValid"}, 32'(o_req_valid), 0);
    checkOutput({name, "_reqAddr"}, 32'(o_req_addr), 0);
    checkOutput({name, "_reqWe"}, 32'(o_req_we), 0);
    checkOutput({name, "_reqWdata"}, 32'(o_req_wdata), 0);
    checkOutput({name, "_dOut"}, 32'(o_d_out), 0);
    checkOutput({name, "_dOe"}, 32'(o_d_oe), 0);
`ifdef STRETCH_TIMEOUT_EN
    checkOutput({name, "_timeout"}, 32'(o_timeout), 0);
`endif
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic presentLow(input vec_t v, input bit expectAccept);
    i_a         = v.addr;
    i_d         = v.bank;
    i_rwb       = v.rwb;
    i_vda       = v.vda;
    i_vpa       = v.vpa;
    i_req_ready = 1'b1;
    i_rsp_valid = 1'b0;
    if (expectAccept) expQ.push_back('{ {v.bank, v.addr}, ~v.rwb, v.wdata });
  endtask

  task automatic waitPhi2(input string name, output bit ok);
    int lowCount;
    lowCount = 1;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(posedge clk); #1;
      if (o_phi2) begin
        ok = 1'b1;
        break;
      end
      lowCount++;
    end
    if (!ok) reportExpired({name, "_phi2Rise"});
    else checkOutput({name, "_lowLen"}, 32'(lowCount), 32'(PHI2_HALF));
  endtask

  // One full bus cycle; starts and ends in the first cycle of a LOW phase.
  task automatic applyStimulus(input vec_t v, input string name);
    int   k;
    int   accBefore;
    bit   ok;
    logic doeLast;
    presentLow(v, v.vda | v.vpa);
    accBefore = acceptCount;
    waitPhi2(name, ok);
    if (!ok) return;
    k = 0;
    doeLast = 1'b0;
    do begin
      i_d         = v.rwb ? v.bank : v.wdata;
      i_rsp_valid = (k == v.rspIdx);
      i_rsp_data  = v.rspData;
      i_req_ready = (k >= v.readyFrom);
      doeLast     = o_d_oe;
      @(posedge clk); #1;
      k++;
    end while (o_phi2 && k < 200);
    i_rsp_valid = 1'b0;
    i_req_ready = 1'b1;
    checkOutput({name, "_highLen"}, 32'(k), 32'(v.expHigh));
    checkOutput({name, "_doeEnd"}, 32'(doeLast), 32'(v.expDoe));
    checkOutput({name, "_dOut"}, 32'(o_d_out), 32'(v.expDout));
    checkOutput({name, "_doeLow"}, 32'(o_d_oe), 0);
    checkOutput({name, "_accepts"}, 32'(acceptCount - accBefore), 32'((v.vda | v.vpa) ? 1 : 0));
  endtask

  vec_t vecs[9];

  initial begin
    vec_t v;
    bit   ok;
    i_reset = 1'b1; i_a = '0; i_d = '0; i_rwb = 1'b1; i_vda = 1'b0; i_vpa = 1'b0;
    i_req_ready = 1'b1; i_rsp_valid = 1'b0; i_rsp_data = '0;

    //            bank   addr      wdata  rwb vda vpa rspIdx data   rdyFrom high dout  doe
    vecs[0] = '{8'h00, 16'hFFFF, 8'h00, 1, 0, 0, -1, 8'h00, 0,  4, 8'h00, 0};
    vecs[1] = '{8'h12, 16'h3456, 8'h00, 1, 1, 0,  2, 8'hA5, 0,  4, 8'hA5, 1};
    vecs[2] = '{8'h7E, 16'h0010, 8'h5A, 0, 1, 0, -1, 8'h00, 0,  4, 8'hA5, 0};
    vecs[3] = '{8'h01, 16'hBEEF, 8'h00, 1, 0, 1,  9, 8'h3C, 0, 11, 8'h3C, 1};
    vecs[4] = '{8'h80, 16'h1234, 8'hC3, 0, 1, 0, -1, 8'h00, 9, 11, 8'h3C, 0};
    vecs[5] = '{8'h55, 16'h0000, 8'h00, 0, 0, 0, -1, 8'h00, 0,  4, 8'h3C, 0};
    vecs[6] = '{8'hFF, 16'h0000, 8'h00, 1, 1, 1,  0, 8'h77, 0,  4, 8'h77, 1};
    vecs[7] = '{8'h40, 16'h8000, 8'h00, 1, 1, 0,  5, 8'h99, 2,  7, 8'h99, 1};
    vecs[8] = '{8'h00, 16'h1111, 8'h00, 1, 0, 0,  1, 8'h11, 0,  4, 8'h99, 0};

    applyReset("reset");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Read held off by the cache until a reset lands in the middle of the stretch.
    v = '{8'h22, 16'h4444, 8'h00, 1, 1, 0, -1, 8'h00, 0, 0, 8'h00, 0};
    presentLow(v, 1'b0);
    i_req_ready = 1'b0;
    waitPhi2("midStretch", ok);
    if (ok) begin
      repeat (6) begin
        @(posedge clk); #1;
      end
      checkOutput("midStretch_phi2High", 32'(o_phi2), 1);
      checkOutput("midStretch_validHigh", 32'(o_req_valid), 1);
      applyReset("midStretchReset");
    end

    // Abandoned handshake must not reappear after reset.
    applyStimulus('{8'h00, 16'h2222, 8'h00, 1, 0, 0, -1, 8'h00, 0, 4, 8'h00, 0}, "postReset");

`ifdef STRETCH_TIMEOUT_EN
    begin
      int k;
      int pulses;
      v = '{8'h33, 16'h5555, 8'h00, 1, 1, 0, -1, 8'h00, 0, 0, 8'h00, 0};
      presentLow(v, 1'b1);
      waitPhi2("timeout", ok);
      if (ok) begin
        k = 0;
        pulses = 0;
        do begin
          if (o_timeout) pulses++;
          @(posedge clk); #1;
          k++;
        end while (o_phi2 && k < 200);
        if (o_timeout) pulses++;
        checkOutput("timeout_highLen", 32'(k), 32'(PHI2_HALF + MAX_STRETCH + 1));
        checkOutput("timeout_pulses", 32'(pulses), 1);
        checkOutput("timeout_dOut", 32'(o_d_out), 32'hFF);
        checkOutput("timeout_validLow", 32'(o_req_valid), 0);
      end
    end
`endif

    checkOutput("queueEmpty", 32'(expQ.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
